// File: rtl/dpll_loop_ctrl.sv
// ADPLL loop filter and lock sequencer: gain-switched up/down counter plus IDLE/ACQUIRE/TRACK/LOCKED FSM.
// Latency: phase event in cycle N -> add/plus pulse in cycle N+1; no backpressure (dco consumes every pulse).
module dpll_loop_ctrl #(
  parameter int KW         = 5,
  parameter int ACQ_K      = 2,
  parameter int TRK_K      = 8,
  parameter int ACQ_FLIPS  = 3,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       lead,
  input  logic       lag,
  input  logic       bothedge,
  output logic       add,
  output logic       plus,
  output logic       locked,
  output logic [1:0] state
);

  localparam int FW = $clog2(ACQ_FLIPS + 1);
  localparam int QW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(UNLOCK_CNT + 1);

  localparam logic signed [KW-1:0] ACQ_KV      = KW'(ACQ_K);
  localparam logic signed [KW-1:0] TRK_KV      = KW'(TRK_K);
  localparam logic [FW-1:0]        ACQ_FLIPS_V = FW'(ACQ_FLIPS);
  localparam logic [QW-1:0]        LOCK_CNT_V  = QW'(LOCK_CNT);
  localparam logic [SW-1:0]        UNLOCK_V    = SW'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACQ  = 2'b01,
    ST_TRK  = 2'b10,
    ST_LCK  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_LEAD = 2'b01,
    DIR_LAG  = 2'b10
  } dir_t;

  state_t               state_q, state_d;
  logic signed [KW-1:0] acc_q, acc_d;
  dir_t                 dir_q, dir_d;
  dir_t                 cdir_q, cdir_d;
  logic [FW-1:0]        flip_cnt_q, flip_cnt_d;
  logic [QW-1:0]        quiet_cnt_q, quiet_cnt_d;
  logic [SW-1:0]        same_cnt_q, same_cnt_d;
  logic                 add_q, add_d;
  logic                 plus_q, plus_d;
  logic                 locked_q, locked_d;

  logic                 ev, ev_lead, ev_lag, hit_p, hit_n, corr;
  logic signed [KW-1:0] step, k_thr, acc_sum;
  dir_t                 ev_dir;

  always_comb begin
    // lead and lag together carry no net direction and behave as bothedge
    ev      = lead | lag | bothedge;
    ev_lead = lead & ~lag;
    ev_lag  = lag & ~lead;
    ev_dir  = ev_lead ? DIR_LEAD : (ev_lag ? DIR_LAG : DIR_NONE);
    step    = ev_lead ? KW'(1) : (ev_lag ? -KW'(1) : '0);
    k_thr   = (state_q == ST_ACQ) ? ACQ_KV : TRK_KV;
    acc_sum = acc_q + step;
    hit_p   = ev && (acc_sum == k_thr);
    hit_n   = ev && (acc_sum == -k_thr);
    corr    = hit_p | hit_n;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    dir_d       = dir_q;
    cdir_d      = cdir_q;
    flip_cnt_d  = flip_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    same_cnt_d  = same_cnt_q;
    add_d       = 1'b0;
    plus_d      = 1'b0;

    if (!enable) begin
      state_d     = ST_IDLE;
      acc_d       = '0;
      dir_d       = DIR_NONE;
      cdir_d      = DIR_NONE;
      flip_cnt_d  = '0;
      quiet_cnt_d = '0;
      same_cnt_d  = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_ACQ;
    end else if (ev) begin
      acc_d  = corr ? '0 : acc_sum;
      add_d  = hit_p;
      plus_d = hit_n;
      if (ev_dir != DIR_NONE) dir_d = ev_dir;

      if (state_q == ST_ACQ) begin
        if ((ev_lead && dir_q == DIR_LAG) || (ev_lag && dir_q == DIR_LEAD))
          flip_cnt_d = flip_cnt_q + 1'b1;
        if (flip_cnt_d == ACQ_FLIPS_V) state_d = ST_TRK;
      end else if (corr) begin
        quiet_cnt_d = '0;
        cdir_d      = ev_dir;
        same_cnt_d  = (cdir_q == ev_dir) ? same_cnt_q + 1'b1 : SW'(1);
        if (same_cnt_d == UNLOCK_V) state_d = ST_ACQ;
      end else if (state_q == ST_TRK) begin
        quiet_cnt_d = quiet_cnt_q + 1'b1;
        if (quiet_cnt_d == LOCK_CNT_V) state_d = ST_LCK;
      end
    end

    // a state change restarts filtering; a pulse from the same event still goes out
    if (state_d != state_q) begin
      acc_d       = '0;
      dir_d       = DIR_NONE;
      cdir_d      = DIR_NONE;
      flip_cnt_d  = '0;
      quiet_cnt_d = '0;
      same_cnt_d  = '0;
    end

    locked_d = (state_d == ST_LCK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      dir_q       <= DIR_NONE;
      cdir_q      <= DIR_NONE;
      flip_cnt_q  <= '0;
      quiet_cnt_q <= '0;
      same_cnt_q  <= '0;
      add_q       <= 1'b0;
      plus_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dir_q       <= dir_d;
      cdir_q      <= cdir_d;
      flip_cnt_q  <= flip_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      same_cnt_q  <= same_cnt_d;
      add_q       <= add_d;
      plus_q      <= plus_d;
      locked_q    <= locked_d;
    end
  end

  assign add    = add_q;
  assign plus   = plus_q;
  assign locked = locked_q;
  assign state  = state_q;

endmodule

// File: tb/tb_dpll_loop_ctrl.sv
// Self-checking bench for dpll_loop_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_dpll_loop_ctrl;

  localparam int ACQ_K      = 2;
  localparam int TRK_K      = 8;
  localparam int ACQ_FLIPS  = 3;
  localparam int LOCK_CNT   = 16;
  localparam int UNLOCK_CNT = 4;

  logic       clk = 1'b0;
  logic       reset, enable, lead, lag, bothedge;
  logic       add, plus, locked;
  logic [1:0] state;

  int checks = 0;
  int fails  = 0;

  // model: state 0..3, acc integer, directions as -1/0/+1
  int m_state, m_acc, m_dir, m_cdir, m_flip, m_quiet, m_same;
  bit m_add, m_plus;

  dpll_loop_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .lead     (lead),
    .lag      (lag),
    .bothedge (bothedge),
    .add      (add),
    .plus     (plus),
    .locked   (locked),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_acc = 0; m_dir = 0; m_cdir = 0; m_flip = 0; m_quiet = 0; m_same = 0;
  endtask

  task automatic model_step(input bit rst, input bit en, input bit ld, input bit lg, input bit be);
    int d, k, nstate;
    m_add  = 0;
    m_plus = 0;
    if (rst || !en) begin
      m_state = 0;
      model_clear();
      return;
    end
    if (m_state == 0) begin
      m_state = 1;
      model_clear();
      return;
    end
    if (!(ld || lg || be)) return;
    d = (ld && !lg) ? 1 : ((lg && !ld) ? -1 : 0);
    k = (m_state == 1) ? ACQ_K : TRK_K;
    nstate = m_state;
    m_acc += d;
    if (m_acc == k) begin m_add = 1; m_acc = 0; end
    else if (m_acc == -k) begin m_plus = 1; m_acc = 0; end
    if (m_state == 1) begin
      if (d != 0 && m_dir == -d) m_flip++;
      if (m_flip == ACQ_FLIPS) nstate = 2;
    end else if (m_add || m_plus) begin
      m_quiet = 0;
      m_same  = (m_cdir == d) ? m_same + 1 : 1;
      m_cdir  = d;
      if (m_same == UNLOCK_CNT) nstate = 1;
    end else if (m_state == 2) begin
      m_quiet++;
      if (m_quiet == LOCK_CNT) nstate = 3;
    end
    if (d != 0) m_dir = d;
    if (nstate != m_state) begin
      m_state = nstate;
      model_clear();
    end
  endtask

  function automatic logic [4:0] exp_vec();
    logic [1:0] s;
    s = m_state[1:0];
    return {m_add, m_plus, (m_state == 3), s};
  endfunction

  task automatic drive(input bit rst, input bit en, input bit ld, input bit lg, input bit be);
    reset = rst; enable = en; lead = ld; lag = lg; bothedge = be;
    @(posedge clk);
    model_step(rst, en, ld, lg, be);
    #1;
  endtask

  task automatic goto_track();
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, i[0], 0, 0);
      checks++;
      if ({add, plus, locked, state} !== 5'b00000) begin
        fails++;
        $display("FAIL reset cyc%0d: add/plus/locked/state=%b%b%b%b expected 00000", i, add, plus, locked, state);
      end
    end
  endtask

  task automatic test_acq_correction();
    bit [2:0] ld_s [7] = '{1, 0, 1, 0, 0, 0, 0};
    bit [2:0] lg_s [7] = '{0, 0, 0, 0, 1, 1, 0};
    logic [4:0] lit [7] = '{5'b00001, 5'b00001, 5'b10001, 5'b00001, 5'b00001, 5'b01001, 5'b00001};
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, ld_s[i][0], lg_s[i][0], 0);
      checks++;
      if ({add, plus, locked, state} !== lit[i] || lit[i] !== exp_vec()) begin
        fails++;
        $display("FAIL acq_corr step%0d: got %b required %b (model %b)", i, {add, plus, locked, state}, lit[i], exp_vec());
      end
    end
  endtask

  task automatic test_acq_to_track();
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, ~i[0], i[0], 0);
      checks++;
      if ({add, plus, locked, state} !== ((i == 3) ? 5'b00010 : 5'b00001)) begin
        fails++;
        $display("FAIL acq_to_track ev%0d: got %b required %b", i, {add, plus, locked, state}, (i == 3) ? 5'b00010 : 5'b00001);
      end
    end
  endtask

  task automatic test_track_lock();
    goto_track();
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, (i == 8), 0, (i != 8));
      checks++;
      if ({add, plus, locked, state} !== ((i == 16) ? 5'b00111 : 5'b00010)) begin
        fails++;
        $display("FAIL track_lock ev%0d: got %b required %b", i, {add, plus, locked, state}, (i == 16) ? 5'b00111 : 5'b00010);
      end
    end
  endtask

  task automatic test_locked_unlock();
    int adds = 0;
    for (int i = 1; i <= 32; i++) begin
      drive(0, 1, 1, 0, 0);
      adds += add;
      checks++;
      if (add !== (i % 8 == 0) || {plus, locked, state} !== ((i == 32) ? 4'b0001 : 4'b0111)) begin
        fails++;
        $display("FAIL locked_unlock lead%0d: add=%b plus/locked/state=%b required add=%b", i, add, {plus, locked, state}, (i % 8 == 0));
      end
    end
    checks++;
    if (adds !== 4) begin
      fails++;
      $display("FAIL locked_unlock add_count: got %0d required 4", adds);
    end
  endtask

  task automatic test_both_and_disable();
    goto_track();
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 1, 1, 0);
      checks++;
      if ({add, plus, locked, state} !== exp_vec()) begin
        fails++;
        $display("FAIL lead_lag ev%0d: got %b required %b", i, {add, plus, locked, state}, exp_vec());
      end
    end
    checks++;
    if (state !== 2'b11) begin
      fails++;
      $display("FAIL lead_lag_lock: state=%b required 11", state);
    end
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    checks++;
    if ({add, plus, locked, state} !== 5'b00000) begin
      fails++;
      $display("FAIL disable_drop: got %b required 00000", {add, plus, locked, state});
    end
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    checks++;
    if ({add, plus, state} !== 4'b0001) begin
      fails++;
      $display("FAIL disable_acc_cleared: got %b required 0001", {add, plus, state});
    end
  endtask

  task automatic test_random();
    bit r, e, ld, lg, be;
    int sel;
    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 499) == 0);
      e   = ($urandom_range(0, 149) != 0);
      sel = $urandom_range(0, 15);
      ld  = (sel < 3) || (sel == 9 && $urandom_range(0, 1) == 1);
      lg  = (sel >= 3 && sel < 6) || sel == 9;
      be  = (sel >= 6 && sel < 9) || (sel == 10);
      drive(r, e, ld, lg, be);
      checks++;
      if ({add, plus, locked, state} !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc%0d: got %b required %b", i, {add, plus, locked, state}, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; lead = 1'b0; lag = 1'b0; bothedge = 1'b0;
    m_state = 0; m_add = 0; m_plus = 0;
    model_clear();
    test_reset();
    test_acq_correction();
    test_acq_to_track();
    test_track_lock();
    test_locked_unlock();
    test_both_and_disable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
